fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction prefetch queue between instruction memory and the IF/ID pipeline register. It replaces the direct combinational PC-to-imem path.
- Generates sequential fetch addresses and issues them to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned {pc, instr} pairs in a FIFO and presents them to decode with a valid/stall interface.
- Flushes and restarts on a branch redirect from the MEM stage.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request to instruction memory; registered.
- mem_addr  out  32  fetch address; registered, stable while mem_req=1.
- mem_ack  in  1  memory response valid; sampled only while mem_req=1.
- mem_rdata  in  32  instruction word, valid with mem_ack.
- redirect  in  1  branch taken; flush queue and restart fetch.
- redirect_pc  in  32  new fetch address, valid with redirect.
- stall  in  1  decode cannot accept this cycle.
- instr_valid  out  1  head entry valid (count≠0).
- instr_out  out  32  head instruction; 32'h0 when empty.
- pc_out  out  32  head PC; 32'h0 when empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, head/tail ptrs=0, fetch_pc=RESET_PC.
  - mem_req=0, mem_addr=RESET_PC.
  - instr_valid=0, instr_out=0, pc_out=0.
  - A reset mid-request drops the outstanding request; the next ack is ignored because mem_req=0.
- Handshake with memory:
  - At most one outstanding request.
  - mem_req, once high, stays high with mem_addr unchanged until the cycle mem_ack=1.
  - mem_req deasserts on the edge after ack.
  - Ack latency ≥1 cycle after mem_req rises.
- Pop: occurs when instr_valid=1 && stall=0. Head advances and count decrements at the edge.
- Push: on a valid ack in WAIT, {fetch_pc, mem_rdata} is written at tail and fetch_pc += 4 (mod 2^32 wrap).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- State machine:
  - IDLE:
    - If redirect: fetch_pc←redirect_pc, flush, stay IDLE.
    - Else if count<DEPTH: mem_req←1, mem_addr←fetch_pc, go WAIT.
    - Else (full): stay IDLE, mem_req=0.
  - WAIT:
    - mem_ack && !redirect: push, mem_req←0, go IDLE.
    - mem_ack && redirect: discard data, flush, fetch_pc←redirect_pc, mem_req←0, go IDLE.
    - !mem_ack && redirect: flush, fetch_pc←redirect_pc, go DRAIN. mem_req stays high with the old address.
    - Otherwise: hold.
  - DRAIN:
    - mem_ack: discard data, mem_req←0, go IDLE.
    - redirect: update fetch_pc←redirect_pc; this applies in the same cycle as mem_ack as well. Last redirect wins.
- Flush: count←0, ptrs←0.
  - Redirect has priority over pop and push in the same cycle.
  - instr_valid=0 on the cycle after redirect.
- Issue check: count<DEPTH in IDLE guarantees no overflow, since one outstanding request plus count is never more than DEPTH.
- Latencies:
  - Ack at edge M → instr_valid=1 after M with the new data.
  - Redirect at edge N → mem_req=1, mem_addr=redirect_pc after edge N+1 (via IDLE), when no request is outstanding.
- redirect_pc low bits are used as given; no alignment check.

Test Plan:
- Reset: hold reset=0 with mem_ack pulsed randomly → all outputs 0, mem_addr=RESET_PC. Release → mem_req=1, mem_addr=0 one cycle later.
- Fill: stall=1, 1-cycle ack, rdata=addr^32'hA5A5_0000 → 4 pushes with PCs 0,4,8,C. mem_req stays 0 when count=4. Head stays pc_out=0, instr_out=32'hA5A5_0000.
- Drain and refill: release stall with 3-cycle ack latency → entries pop in order 0,4,8,C. Fetch resumes at 0x10 once count<4, with no duplicate or lost PC.
- Redirect during WAIT: redirect to 0x100 two cycles before ack → ack data discarded, instr_valid=0. Next mem_addr=0x100; first valid pc_out=0x100.
- Redirect coincident with ack, then a second redirect in DRAIN:
  - Case A (redirect same cycle as ack): → no push, next request at the redirect address.
  - Case B (redirect 0x200 while waiting, then 0x300 during DRAIN): → fetch resumes at 0x300.
- Mid-operation reset while mem_req=1 → mem_req=0 immediately, queue empty. A late ack is ignored and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches over a single-outstanding
// req/ack handshake and buffers {pc, instr} pairs for decode, flushing on redirect.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [PTR_W-1:0]   r_head, r_tail, w_head_nxt, w_tail_nxt;
   logic [CNT_W-1:0]   r_count, w_count_nxt;
   logic [31:0]        r_fetch_pc, w_fetch_pc_nxt;
   logic               w_req_nxt;
   logic [31:0]        w_addr_nxt;
   logic               w_push, w_pop, w_flush, w_bypass;
   logic [31:0]        w_head_pc, w_head_ins;
   logic [31:0]        r_pc_mem  [DEPTH];
   logic [31:0]        r_ins_mem [DEPTH];

   // Next-state, handshake and queue-pointer logic; redirect overrides push and pop
   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = mem_req;
      w_addr_nxt     = mem_addr;
      w_fetch_pc_nxt = r_fetch_pc;
      w_push         = 1'b0;
      w_flush        = redirect;
      w_pop          = (r_count != '0) && !stall && !redirect;

      case (r_state)
         S_IDLE: begin
            if (redirect) begin
               w_fetch_pc_nxt = redirect_pc;
            end else if (r_count < CNT_W'(DEPTH)) begin
               w_req_nxt   = 1'b1;
               w_addr_nxt  = r_fetch_pc;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
               if (redirect) begin
                  w_fetch_pc_nxt = redirect_pc;
               end else begin
                  w_push         = 1'b1;
                  w_fetch_pc_nxt = r_fetch_pc + 32'd4;
               end
            end else if (redirect) begin
               w_fetch_pc_nxt = redirect_pc;
               w_state_nxt    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (redirect) w_fetch_pc_nxt = redirect_pc;
            if (mem_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_flush) begin
         w_head_nxt  = '0;
         w_tail_nxt  = '0;
         w_count_nxt = '0;
      end else begin
         w_head_nxt  = r_head + PTR_W'(w_pop);
         w_tail_nxt  = r_tail + PTR_W'(w_push);
         w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end

      // A push into an otherwise-empty queue becomes the new head directly
      w_bypass = w_push && (r_tail == w_head_nxt);
      if (w_count_nxt == '0) begin
         w_head_pc  = 32'h0;
         w_head_ins = 32'h0;
      end else if (w_bypass) begin
         w_head_pc  = r_fetch_pc;
         w_head_ins = mem_rdata;
      end else begin
         w_head_pc  = r_pc_mem[w_head_nxt];
         w_head_ins = r_ins_mem[w_head_nxt];
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_fetch_pc  <= RESET_PC;
         mem_req     <= 1'b0;
         mem_addr    <= RESET_PC;
         instr_valid <= 1'b0;
         instr_out   <= 32'h0;
         pc_out      <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_head      <= w_head_nxt;
         r_tail      <= w_tail_nxt;
         r_count     <= w_count_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         mem_req     <= w_req_nxt;
         mem_addr    <= w_addr_nxt;
         instr_valid <= (w_count_nxt != '0);
         instr_out   <= w_head_ins;
         pc_out      <= w_head_pc;
      end
   end

   // Entry storage needs no reset; occupancy is tracked by r_count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_tail]  <= r_fetch_pc;
         r_ins_mem[r_tail] <= mem_rdata;
      end
   end

endmodule
